// File: rtl/mod_exp_arbiter_if.sv
// rtl/mod_exp_arbiter_if.sv - requester, response and engine signal bundle for mod_exp_arbiter
// Optional rsp_cycles exists only when MOD_EXP_ARB_CYCLES_EN is defined.
interface mod_exp_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_base;
  logic [N_REQ*WIDTH-1:0] req_exponent;
  logic [N_REQ*WIDTH-1:0] req_modulo;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_result;
  logic                   rsp_err;
`ifdef MOD_EXP_ARB_CYCLES_EN
  logic [15:0]            rsp_cycles;
`endif

  logic                   exp_valid;
  logic [WIDTH-1:0]       exp_base;
  logic [WIDTH-1:0]       exp_exponent;
  logic [WIDTH-1:0]       exp_modulo;
  logic                   exp_ready;
  logic [WIDTH-1:0]       exp_result;

  // slave: the arbiter; master: requesters, response sink and engine
  modport slave (
    input  req_valid, req_base, req_exponent, req_modulo, rsp_ready, exp_ready, exp_result,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err,
           exp_valid, exp_base, exp_exponent, exp_modulo
`ifdef MOD_EXP_ARB_CYCLES_EN
    , output rsp_cycles
`endif
  );

  modport master (
    output req_valid, req_base, req_exponent, req_modulo, rsp_ready, exp_ready, exp_result,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err,
           exp_valid, exp_base, exp_exponent, exp_modulo
`ifdef MOD_EXP_ARB_CYCLES_EN
    , input rsp_cycles
`endif
  );
endinterface

// File: rtl/mod_exp_arbiter.sv
// rtl/mod_exp_arbiter.sv - round-robin sharing of one mod_exp engine among N_REQ requesters
// Define MOD_EXP_ARB_CYCLES_EN to add the rsp_cycles WAIT-cycle counter.
module mod_exp_arbiter #(
  parameter int WIDTH = 32,
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic              clk,
  input  logic              rst,
  mod_exp_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e           state_q;
  logic [ID_W-1:0]  rr_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [WIDTH-1:0] base_q;
  logic [WIDTH-1:0] exponent_q;
  logic [WIDTH-1:0] modulo_q;
  logic [WIDTH-1:0] result_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic             exp_valid_q;
`ifdef MOD_EXP_ARB_CYCLES_EN
  logic [15:0]      cycles_q;
`endif

  logic             gnt_found;
  logic [ID_W-1:0]  gnt_idx;
  logic             grant;
  logic [WIDTH-1:0] gnt_modulo;
  int               cand;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(rr_q) + k) % N_REQ;
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(cand);
      end
    end
  end

  // exp_ready gating in IDLE also drains any engine job left running across reset
  assign grant         = (state_q == IDLE) && bus.exp_ready && gnt_found;
  assign bus.req_ready = grant ? (N_REQ'(1) << gnt_idx) : '0;
  assign gnt_modulo    = bus.req_modulo[gnt_idx*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      rsp_id_q    <= '0;
      base_q      <= '0;
      exponent_q  <= '0;
      modulo_q    <= '0;
      result_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      exp_valid_q <= 1'b0;
`ifdef MOD_EXP_ARB_CYCLES_EN
      cycles_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (grant) begin
          base_q     <= bus.req_base[gnt_idx*WIDTH +: WIDTH];
          exponent_q <= bus.req_exponent[gnt_idx*WIDTH +: WIDTH];
          modulo_q   <= gnt_modulo;
          rsp_id_q   <= gnt_idx;
          rr_q       <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
`ifdef MOD_EXP_ARB_CYCLES_EN
          cycles_q   <= '0;
`endif
          // moduli 0 and 1 never reach the engine
          if (gnt_modulo[WIDTH-1:1] == '0) begin
            result_q    <= '0;
            rsp_err_q   <= ~gnt_modulo[0];
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            rsp_err_q   <= 1'b0;
            exp_valid_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          exp_valid_q <= 1'b0;
          state_q     <= WAIT;
        end
        WAIT: begin
          if (bus.exp_ready) begin
            result_q    <= bus.exp_result;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
`ifdef MOD_EXP_ARB_CYCLES_EN
          else if (cycles_q != 16'hFFFF) begin
            cycles_q <= cycles_q + 16'd1;
          end
`endif
        end
        RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_result   = result_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.exp_valid    = exp_valid_q;
  assign bus.exp_base     = base_q;
  assign bus.exp_exponent = exponent_q;
  assign bus.exp_modulo   = modulo_q;
`ifdef MOD_EXP_ARB_CYCLES_EN
  assign bus.rsp_cycles   = cycles_q;
`endif
endmodule

// File: tb/tb_mod_exp_arbiter.sv
// tb/tb_mod_exp_arbiter.sv - directed scoreboard bench for mod_exp_arbiter with a behavioural engine
module tb_mod_exp_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod_exp_arbiter_if #(.WIDTH(32), .N_REQ(2), .ID_W(1)) bus ();
  mod_exp_arbiter #(.WIDTH(32), .N_REQ(2), .ID_W(1)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        err;
    logic [15:0] cyc;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_fail = 0;
  int ev_cnt = 0;

  function automatic logic [31:0] f_modexp(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
    logic [63:0] r, x;
    r = 64'd1 % {32'd0, m};
    x = {32'd0, b} % {32'd0, m};
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % {32'd0, m};
      x = (x * x) % {32'd0, m};
    end
    return r[31:0];
  endfunction

  function automatic int f_busy(input logic [31:0] e);
    int n;
    n = 1;
    for (int i = 0; i < 32; i++) if (e[i]) n = i + 1;
    return n;
  endfunction

  // engine model: no reset, ready low for exactly max(1, bitlen(e)) cycles after an issue
  logic        eng_busy = 1'b0;
  int          eng_cnt = 0;
  logic [31:0] eng_res = 32'd0;
  assign bus.exp_ready  = ~eng_busy;
  assign bus.exp_result = eng_res;

  always @(posedge clk) begin
    if (bus.exp_valid) ev_cnt <= ev_cnt + 1;
    if (eng_busy) begin
      if (eng_cnt == 1) eng_busy <= 1'b0;
      eng_cnt <= eng_cnt - 1;
    end else if (bus.exp_valid) begin
      eng_busy <= 1'b1;
      eng_cnt  <= f_busy(bus.exp_exponent);
      eng_res  <= f_modexp(bus.exp_base, bus.exp_exponent, bus.exp_modulo);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_id"}, bus.rsp_id, 0);
    check({tag, "_rsp_result"}, bus.rsp_result, 0);
    check({tag, "_rsp_err"}, bus.rsp_err, 0);
    check({tag, "_exp_valid"}, bus.exp_valid, 0);
    check({tag, "_exp_ops"}, {bus.exp_base, bus.exp_exponent}, 0);
    check({tag, "_exp_mod"}, bus.exp_modulo, 0);
`ifdef MOD_EXP_ARB_CYCLES_EN
    check({tag, "_rsp_cycles"}, bus.rsp_cycles, 0);
`endif
  endtask

  task automatic set_req(input int id, input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
    bus.req_base[id*32 +: 32]     = b;
    bus.req_exponent[id*32 +: 32] = e;
    bus.req_modulo[id*32 +: 32]   = m;
    bus.req_valid[id]             = 1'b1;
  endtask

  // called just after a negedge; returns just after the negedge following the grant edge
  task automatic issue_job(input int id, input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
    bit   got;
    exp_t x;
    got = 0;
    set_req(id, b, e, m);
    for (int k = 0; k < 400; k++) begin
      #1;
      if (bus.req_ready != 0) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    check("grant_seen", got, 1);
    if (!got) return;
    check("grant_onehot", bus.req_ready, 2'b01 << id);
    x.id  = id;
    x.err = (m == 0);
    x.res = (m <= 1) ? 32'd0 : f_modexp(b, e, m);
    x.cyc = (m <= 1) ? 16'd0 : 16'(f_busy(e));
    sb.push_back(x);
    @(negedge clk);
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    bit   got;
    exp_t x;
    got = 0;
    for (int k = 0; k < 400; k++) begin
      #1;
      if (bus.rsp_valid) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_rsp_seen"}, got, 1);
    if (!got) return;
    check({tag, "_sb_nonempty"}, sb.size() != 0, 1);
    if (sb.size() == 0) return;
    x = sb.pop_front();
    check({tag, "_id"}, bus.rsp_id, x.id);
    check({tag, "_result"}, bus.rsp_result, x.res);
    check({tag, "_err"}, bus.rsp_err, x.err);
`ifdef MOD_EXP_ARB_CYCLES_EN
    check({tag, "_cycles"}, bus.rsp_cycles, x.cyc);
`endif
    if (bus.rsp_ready) @(negedge clk);
  endtask

  int ev0;
  bit drained;

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_base  = '0;
    bus.req_exponent = '0;
    bus.req_modulo   = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // single job with one engine issue
    ev0 = ev_cnt;
    issue_job(0, 32'd4, 32'd13, 32'd497);
    wait_rsp("basic");
    check("basic_issue_count", ev_cnt - ev0, 1);

    // fresh rr pointer, then two contending requesters
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 32'd5, 32'd3, 32'd13);
    set_req(1, 32'd5, 32'd3, 32'd13);
    for (int g = 0; g < 4; g++) begin
      issue_job(g % 2, 32'd5, 32'd3, 32'd13);
      wait_rsp("rr");
      bus.req_valid[g % 2] = 1'b1;
    end
    bus.req_valid = '0;
    @(negedge clk);

    // exponent 0 and bypassed moduli
    issue_job(0, 32'd7, 32'd0, 32'd11);
    wait_rsp("exp0");
    ev0 = ev_cnt;
    issue_job(1, 32'd9, 32'd5, 32'd1);
    wait_rsp("mod1");
    check("mod1_no_issue", ev_cnt - ev0, 0);
    ev0 = ev_cnt;
    issue_job(0, 32'd9, 32'd5, 32'd0);
    wait_rsp("mod0");
    check("mod0_no_issue", ev_cnt - ev0, 0);

    // response back-pressure with a competing requester pending
    bus.rsp_ready = 1'b0;
    issue_job(0, 32'd3, 32'd7, 32'd100);
    set_req(1, 32'd6, 32'd2, 32'd7);
    for (int k = 0; k < 100 && !bus.rsp_valid; k++) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check("hold_valid", bus.rsp_valid, 1);
      check("hold_fields", {bus.rsp_id, bus.rsp_err, bus.rsp_result}, {1'b0, 1'b0, 32'd87});
      check("hold_no_grant", bus.req_ready, 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    wait_rsp("hold");
    check("hold_released", bus.rsp_valid, 0);
    issue_job(1, 32'd6, 32'd2, 32'd7);
    wait_rsp("after_hold");

    // reset while the engine runs a long job; stale result must never surface
    issue_job(0, 32'd3, 32'hFFFF_FFFF, 32'd1000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    check("midrst_engine_busy", eng_busy, 1);
    rst = 1'b0;
    sb.delete();
    set_req(1, 32'd2, 32'd10, 32'd1000);
    drained = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (!eng_busy) begin
        drained = 1;
        break;
      end
      check("drain_no_grant", bus.req_ready, 0);
      @(negedge clk);
    end
    check("drain_done", drained, 1);
    issue_job(1, 32'd2, 32'd10, 32'd1000);
    wait_rsp("post_rst");

    issue_job(0, 32'd2, 32'd8, 32'd1000);
    wait_rsp("cycles");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
